uart_tx_fsm: RTL and testbench

UART_TX_FSM -- requirements
Module: uart_tx_fsm

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fsm_bit_timer.sv | 35 +++
 rtl/uart_tx_fsm.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver:
// the frame state encoding and the data width and idle line level.
package uart_pkg;

    localparam int   UART_DATA_W = 8;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fsm_bit_timer.sv
// Bit-period counter for the UART transmitter: counts 0..CLKS_PER_BIT-1,
// flags the last cycle of each bit with bit_end_o, and restarts on demand.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Depends only on the count so the FSM's restart request cannot loop back.
    assign bit_end_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: 8N1 frames, or 8E1/8O1 when UART_TX_PARITY_EN is defined.
// The serial line is a flop loaded from the next state, so tx follows acceptance by one cycle.
//
//   state  | meaning
//   IDLE   | line high, tx_ready high, waiting for tx_valid
//   START  | start bit (line low) for one bit period
//   DATA   | eight data bits, LSB first, one bit period each
//   PARITY | parity bit (only with UART_TX_PARITY_EN)
//   STOP   | stop bit (line high); tx_done pulses on the return to IDLE
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    if (CLKS_PER_BIT < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_tx_fsm: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
    end

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   bit_end;
    logic                   restart;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .bit_end_o (bit_end)
    );

    // The timer stays cleared in IDLE and restarts on every state change.
    assign restart = (state_d != state_q) || (state_q == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LEVEL;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: begin
                // IDLE, plus any unreachable encoding, which recovers as IDLE.
                state_d   = IDLE;
                bit_idx_d = '0;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
        endcase
    end

    always_comb begin
        tx_ready = 1'b0;
        tx_d     = IDLE_LEVEL;
        done_d   = (state_q == STOP) && bit_end;
        case (state_q)
            START, DATA, STOP: tx_ready = 1'b0;
`ifdef UART_TX_PARITY_EN
            PARITY:            tx_ready = 1'b0;
`endif
            default:           tx_ready = 1'b1;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = !tx_ready;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: an even- and an odd-parity instance share stimulus and
// are checked every cycle against a frame model built from cycles-since-acceptance.
module tb_uart_tx_fsm;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_CYC = NBITS * C;
    localparam int DONE_LAT  = FRAME_CYC + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx0, rdy0, busy0, done0;
    logic       tx1, rdy1, busy1, done1;

    always #5 clk = ~clk;

    uart_tx_fsm #(.CLKS_PER_BIT(C), .PARITY_ODD(0)) u_even (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_fsm #(.CLKS_PER_BIT(C), .PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: k = cycles since acceptance (0 = idle, DONE_LAT = first idle cycle with done).
    int         k = 0;
    logic [7:0] mbyte = 8'h00;

    function automatic logic exp_tx(input logic [7:0] b, input bit odd, input int kk);
        int idx;
        if (kk < 1 || kk > FRAME_CYC) return 1'b1;
        idx = (kk - 1) / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR_EN && idx == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= 0;
        end else if ((k == 0 || k == DONE_LAT) && tx_valid) begin
            k     <= 1;
            mbyte <= tx_data;
        end else if (k == 0 || k == DONE_LAT) begin
            k <= 0;
        end else begin
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        logic er, ed;
        er = (k == 0) || (k == DONE_LAT);
        ed = (k == DONE_LAT);
        chk("tx_even",    tx0,   exp_tx(mbyte, 1'b0, k));
        chk("tx_odd",     tx1,   exp_tx(mbyte, 1'b1, k));
        chk("ready_even", rdy0,  er);
        chk("ready_odd",  rdy1,  er);
        chk("busy_even",  busy0, !er);
        chk("busy_odd",   busy1, !er);
        chk("done_even",  done0, ed);
        chk("done_odd",   done1, ed);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one byte, then record both lines for 60 cycles after acceptance.
    task automatic send_capture(input logic [7:0] b, output int lat,
                                output logic [63:0] s0, output logic [63:0] s1);
        int budget;
        s0 = '1;
        s1 = '1;
        lat = -1;
        budget = 0;
        step();
        while (!rdy0 && budget < 200) begin
            step();
            budget++;
        end
        chk("ready_before_send", rdy0, 1'b1);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
        for (int kk = 1; kk <= 60; kk++) begin
            tx_data = 8'($urandom);
            @(negedge clk);
            s0[kk] = tx0;
            s1[kk] = tx1;
            if (done0 && lat < 0) lat = kk;
        end
    endtask

    logic a5_exp [NBITS];

    initial begin
        int lat, first_done, second_done;
        logic [63:0] s0, s1;

        // Reset state, checked while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_tx", tx0, 1'b1);
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        step();
        reset = 1'b1;

        // 0xA5 frame pinned bit by bit.
`ifdef UART_TX_PARITY_EN
        a5_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        a5_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        send_capture(8'hA5, lat, s0, s1);
        chk_int("a5_done_latency", lat, PAR_EN ? 45 : 41);
        for (int i = 0; i < NBITS; i++) begin
            chk($sformatf("a5_bit%0d_first", i), s0[i*C+1], a5_exp[i]);
            chk($sformatf("a5_bit%0d_last", i),  s0[i*C+C], a5_exp[i]);
        end
        chk("a5_idle_after", s0[FRAME_CYC+1], 1'b1);

        // Odd parity corner bytes; without parity the same slot is the stop bit.
        send_capture(8'h01, lat, s0, s1);
`ifdef UART_TX_PARITY_EN
        chk("odd_par_01", s1[38], 1'b0);
        chk("even_par_01", s0[38], 1'b1);
`else
        chk("stop_01", s1[38], 1'b1);
`endif
        send_capture(8'h00, lat, s0, s1);
`ifdef UART_TX_PARITY_EN
        chk("odd_par_00", s1[38], 1'b1);
        chk("even_par_00", s0[38], 1'b0);
`else
        chk("stop_00", s1[38], 1'b1);
`endif

        // All-ones byte: stop follows data bit 7 directly.
        send_capture(8'hFF, lat, s0, s1);
        chk_int("ff_done_latency", lat, PAR_EN ? 45 : 41);
        chk("ff_start", s0[4], 1'b0);
        chk("ff_bit0", s0[5], 1'b1);
        chk("ff_bit7", s0[36], 1'b1);

        // tx_valid held high with changing data: back-to-back frames.
        step();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        first_done = -1;
        second_done = -1;
        for (int i = 1; i <= 2 * DONE_LAT + 4; i++) begin
            step();
            tx_data = 8'($urandom);
            if (done0 && first_done < 0) first_done = i;
            else if (done0 && second_done < 0) second_done = i;
            if (i == DONE_LAT + 1) chk("b2b_restart_low", tx0, 1'b0);
        end
        chk_int("b2b_first_done", first_done, DONE_LAT);
        chk_int("b2b_second_done", second_done, 2 * DONE_LAT);
        tx_valid = 1'b0;
        repeat (FRAME_CYC + 2) step();

        // Reset during data bit 3.
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        step();
        tx_valid = 1'b0;
        repeat (17) step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", tx0, 1'b1);
        chk("mid_rst_ready", rdy0, 1'b1);
        chk("mid_rst_done", done0, 1'b0);
        repeat (3) begin
            step();
            chk("mid_rst_no_done", done0, 1'b0);
        end
        reset = 1'b1;
        send_capture(8'h5A, lat, s0, s1);
        chk_int("post_rst_done_latency", lat, DONE_LAT);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step();
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 249) != 0);
        end
        step();
        reset = 1'b1;
        tx_valid = 1'b0;
        repeat (FRAME_CYC + 3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
